// File: rtl/noise_gate_if.sv
// Sample stream bundle for noise_gate: input sample/valid and gated output sample/valid.
// The master drives the input side; the slave (the gate) drives the output side.
interface noise_gate_if #(
  parameter int WIDTH = 32
) ();
  logic             io_in_valid;
  logic [WIDTH-1:0] io_in_value;
  logic             io_out_valid;
  logic [WIDTH-1:0] io_out_value;

  modport master (
    output io_in_valid, io_in_value,
    input  io_out_valid, io_out_value
  );

  modport slave (
    input  io_in_valid, io_in_value,
    output io_out_valid, io_out_value
  );
endinterface

// File: rtl/noise_gate.sv
// Downward-expanding noise gate: peak envelope, five-state hysteresis FSM with hold and linear gain ramps.
// Optional NOISE_GATE_DEBUG_EN exposes the envelope register and the gate state.
module noise_gate #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned FRAC         = 20,
  parameter int unsigned THRESH_OPEN  = 65536,
  parameter int unsigned THRESH_CLOSE = 32768,
  parameter int unsigned HOLD_SAMPLES = 64,
  parameter int unsigned GAIN_STEP    = 16384,
  parameter int unsigned DECAY_SHIFT  = 6
) (
  input  logic          clock,
  input  logic          reset,
  noise_gate_if.slave   bus
`ifdef NOISE_GATE_DEBUG_EN
  ,
  output logic [WIDTH-1:0] io_env_value,
  output logic [2:0]       io_gate_state
`endif
);

  localparam int GW = FRAC + 1;
  localparam int CW = $clog2(HOLD_SAMPLES + 1);

  localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SMAX     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] TH_OPEN  = WIDTH'(THRESH_OPEN);
  localparam logic [WIDTH-1:0] TH_CLOSE = WIDTH'(THRESH_CLOSE);
  localparam logic [GW-1:0]    ONE_G    = {1'b1, {FRAC{1'b0}}};
  localparam logic [GW-1:0]    STEP     = GW'(GAIN_STEP);
  localparam logic [CW-1:0]    HOLD_LD  = CW'(HOLD_SAMPLES - 1);

  typedef enum logic [2:0] {
    ST_CLOSED  = 3'd0,
    ST_OPENING = 3'd1,
    ST_OPEN    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_CLOSING = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    env_q, env_d;
  logic [GW-1:0]       gain_q, gain_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    x_q;
  logic [GW-1:0]       g_q;
  logic                v1_q;
  logic                out_valid_q;
  logic [WIDTH-1:0]    out_value_q;

  logic [WIDTH-1:0]    abs_val, decayed;
  logic [GW-1:0]       gain_up, gain_dn;
  logic                open_hit, below_close;
  logic signed [63:0]  prod;
  logic [WIDTH-1:0]    out_next;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    abs_val = bus.io_in_value;
    if (bus.io_in_value[WIDTH-1]) begin
      abs_val = (bus.io_in_value == SMIN) ? SMAX : -bus.io_in_value;
    end
    decayed     = env_q - (env_q >> DECAY_SHIFT);
    env_d       = (abs_val > decayed) ? abs_val : decayed;
    open_hit    = (env_d >= TH_OPEN);
    below_close = (env_d < TH_CLOSE);
    gain_up     = (gain_q >= ONE_G - STEP) ? ONE_G : gain_q + STEP;
    gain_dn     = (gain_q <= STEP) ? '0 : gain_q - STEP;
  end

  // Next-state logic; only consulted on valid samples.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLOSED:  if (open_hit) state_d = ST_OPENING;
      ST_OPENING: if (gain_up == ONE_G) state_d = ST_OPEN;
      ST_OPEN:    if (below_close) state_d = ST_HOLD;
      ST_HOLD: begin
        if (open_hit)            state_d = ST_OPEN;
        else if (cnt_q == '0)    state_d = ST_CLOSING;
      end
      ST_CLOSING: begin
        if (open_hit)            state_d = ST_OPENING;
        else if (gain_dn == '0)  state_d = ST_CLOSED;
      end
      default:                   state_d = ST_CLOSED;
    endcase
  end

  // Gain follows the state being entered, so the ramp starts on the very sample that opens the gate.
  always_comb begin
    gain_d = gain_q;
    cnt_d  = cnt_q;
    unique case (state_d)
      ST_CLOSED:  gain_d = '0;
      ST_OPENING: gain_d = gain_up;
      ST_OPEN:    gain_d = ONE_G;
      ST_HOLD:    gain_d = ONE_G;
      ST_CLOSING: gain_d = gain_dn;
      default:    gain_d = '0;
    endcase
    if (state_q == ST_OPEN && state_d == ST_HOLD) begin
      cnt_d = HOLD_LD;
    end else if (state_q == ST_HOLD && state_d == ST_HOLD) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // 64-bit signed product, arithmetic shift by FRAC, truncate; gain=ONE returns x exactly.
  assign prod     = 64'($signed(x_q)) * $signed(64'({1'b0, g_q}));
  assign out_next = WIDTH'(prod >>> FRAC);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_CLOSED;
      env_q       <= '0;
      gain_q      <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      g_q         <= '0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
    end else begin
      v1_q        <= bus.io_in_valid;
      out_valid_q <= v1_q;
      if (bus.io_in_valid) begin
        x_q     <= bus.io_in_value;
        g_q     <= gain_q;
        env_q   <= env_d;
        state_q <= state_d;
        gain_q  <= gain_d;
        cnt_q   <= cnt_d;
      end
      if (v1_q) begin
        out_value_q <= out_next;
      end
    end
  end

  assign bus.io_out_valid = out_valid_q;
  assign bus.io_out_value = out_value_q;

`ifdef NOISE_GATE_DEBUG_EN
  assign io_env_value  = env_q;
  assign io_gate_state = state_q;
`endif

endmodule

// File: doc/noise_gate.md
# noise_gate

Downward-expanding noise gate for the fixed-point audio effect chain; it is the complementary dynamics block to the peak limiter. The limiter clamps loud peaks; this block attenuates quiet passages to silence. A peak envelope follower drives a five-state gate FSM with hysteresis, a hold counter and linear gain ramps. Samples are signed 32-bit with 20 fractional bits, and the gate sits in the same per-sample stream position as the limiter.

## Interface
- `WIDTH`, 32: sample width, signed two's complement.
- `FRAC`, 20: fractional bits; unity gain ONE = 1<<FRAC = 1048576.
- `THRESH_OPEN`, 65536: envelope level at or above which the gate opens.
- `THRESH_CLOSE`, 32768: envelope level below which the gate starts to close. Must be ≤ THRESH_OPEN.
- `HOLD_SAMPLES`, 64: number of valid samples the gate stays open after the envelope falls below THRESH_CLOSE.
- `GAIN_STEP`, 16384: gain change per valid sample while ramping (64-sample ramp by default).
- `DECAY_SHIFT`, 6: envelope release; per sample, env -= env>>DECAY_SHIFT.
- `clock`  in  1  single clock. All state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `io_in_valid`  in  1  a sample is present this cycle.
- `io_in_value`  in  WIDTH  input sample.
- `io_out_valid`  out  1  io_out_value is updated this cycle.
- `io_out_value`  out  WIDTH  gated sample. Holds its value between valid samples.

## Operation
- Every internal update is qualified by io_in_valid. When io_in_valid=0, env, state, gain and hold counter are frozen.
- abs: |x|. For x = -2^31 the result saturates to 0x7FFFFFFF.
- Envelope (unsigned, WIDTH): env_n = max(abs_n, env_{n-1} - (env_{n-1}>>DECAY_SHIFT)).
- Gain register is unsigned, range 0..ONE. Sample n is multiplied by the gain held before sample n's update.
- Output: (x * gain) as a 64-bit signed product, arithmetic-shifted right by FRAC, truncated to WIDTH. No rounding. gain=ONE returns x bit-exact.
- FSM transitions use env_n, evaluated on the same valid sample. The first matching rule in each state wins.
  - CLOSED: gain=0. env_n ≥ THRESH_OPEN → OPENING.
  - OPENING: gain += GAIN_STEP, saturating at ONE. When the result equals ONE → OPEN.
  - OPEN: gain=ONE. env_n < THRESH_CLOSE → HOLD, and the hold counter loads HOLD_SAMPLES-1.
  - HOLD: gain=ONE.
    - env_n ≥ THRESH_OPEN → OPEN.
    - Otherwise, counter==0 → CLOSING.
    - Otherwise, counter decrements.
  - CLOSING: gain -= GAIN_STEP, floored at 0.
    - env_n ≥ THRESH_OPEN → OPENING.
    - Otherwise, when the result equals 0 → CLOSED.
- Between THRESH_CLOSE and THRESH_OPEN (the hysteresis band), OPEN stays OPEN and CLOSED stays CLOSED.

## Timing
- Reset (synchronous) values: io_out_valid=0, io_out_value=0, env=0, gain=0, hold counter=0, state=CLOSED.
- Reset takes effect at the next edge and overrides everything, including a mid-ramp or an in-flight pipeline sample. Pipeline valid bits clear.
- Pipeline has 2 stages:
  - Edge ending cycle t (io_in_valid=1): registers x_d, g_d (pre-update gain), env, state, gain and counter.
  - Edge ending t+1: registers io_out_value and sets io_out_valid.
  - io_out_valid is high for one cycle, in cycle t+2.
- Back-to-back valid samples give one result every cycle, with no stall and no backpressure.
- io_out_valid mirrors io_in_valid delayed by 2 cycles, gaps included.

## Configuration
- `NOISE_GATE_DEBUG_EN`
  - Defined: adds output `io_env_value` (WIDTH, the current env register) and output `io_gate_state` (3 bits).
  - io_gate_state encoding: CLOSED=0, OPENING=1, OPEN=2, HOLD=3, CLOSING=4.
  - Both debug outputs reset to 0.
  - Undefined: the ports and the logic driving them are absent. Datapath behaviour is identical either way.

## Test plan
- Reset, then a constant input of 16384 with valid every cycle for 500 cycles → io_out_value=0 throughout, and the gate never leaves CLOSED.
- After reset, a constant input of 524288 → output sample k (k=0..64) equals 8192·k. From sample 64 onward the output is exactly 524288 (OPEN).
- From OPEN, the input drops to 16384 → env decays below 32768 after a finite number of samples. The output then stays 16384 for 64 further samples (HOLD). The output then ramps down by 256 per sample to 0 (CLOSED).
- Input 0x80000000 held → abs saturates and the gate opens. Once OPEN, io_out_value = 0x80000000 exactly.
- Assert reset mid-OPENING (gain ≈ ONE/2) → the next cycle shows io_out_valid=0, io_out_value=0 and state CLOSED. A post-reset input of 524288 restarts the ramp from 0.
- Input 524288 with io_in_valid toggling 1,0,0,1 → the ramp advances only on valid samples. io_out_valid follows the pattern 2 cycles later, and io_out_value holds during gaps.
